meter_timer: RTL and testbench

METER_TIMER -- requirements
Module: meter_timer

---
 rtl/meter_timer_if.sv | 21 ++
 rtl/meter_timer.sv | 128 ++++++++++++
 tb/tb_meter_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/meter_timer_if.sv
// Bus bundle for the meter countdown timer: preset value in, remaining
// time and display controls out. clk/rst_n are kept as plain ports.
interface meter_timer_if;
  logic [13:0] val_in;
  logic        load;
  logic [13:0] time_out;
  logic        blank;
  logic [1:0]  mode;

  // driven by the add/preset logic (or a bench)
  modport master (
    output val_in, load,
    input  time_out, blank, mode
  );

  // the timer itself
  modport slave (
    input  val_in, load,
    output time_out, blank, mode
  );
endinterface

// File: rtl/meter_timer.sv
// Parking-meter countdown timer. A free-running prescaler produces a
// half-second tick and a one-second tick. Remaining time counts down once
// per second and saturates at zero. The display blinks slowly when time is
// low and quickly when time has expired.
module meter_timer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int LOW_THRESH = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  meter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_LOW     = 2'd1,
    MODE_EXPIRED = 2'd2
  } mode_t;

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(HALF - 1);
  localparam logic [13:0]   TIME_MAX  = 14'd9999;
  localparam logic [13:0]   LOW_T     = 14'(LOW_THRESH);

  logic [PW-1:0] presc_r;
  logic          parity_r;
  logic          half_tick_s;
  logic          sec_tick_s;

  logic [13:0]   load_val_s;
  logic [13:0]   time_r;
  logic [13:0]   time_next_s;
  mode_t         mode_r;
  mode_t         mode_next_s;
  logic          blank_r;
  logic          blank_next_s;

  // Mode for a given remaining time; the value is already clamped.
  function automatic mode_t classify(input logic [13:0] t);
    mode_t m;
    if (t == 14'd0) begin
      m = MODE_EXPIRED;
    end else if (t < LOW_T) begin
      m = MODE_LOW;
    end else begin
      m = MODE_NORMAL;
    end
    return m;
  endfunction

  // Tick decode: half tick on prescaler wrap, second tick on every other one.
  always_comb begin
    half_tick_s = 1'b0;
    if (presc_r == PRESC_MAX) begin
      half_tick_s = 1'b1;
    end else begin
      half_tick_s = 1'b0;
    end
    sec_tick_s = half_tick_s & parity_r;
  end

  // Free-running prescaler and half-tick parity; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r  <= '0;
      parity_r <= 1'b0;
    end else if (half_tick_s) begin
      presc_r  <= '0;
      parity_r <= ~parity_r;
    end else begin
      presc_r  <= presc_r + PW'(1);
      parity_r <= parity_r;
    end
  end

  // Next remaining time: a load beats a coincident tick; zero saturates.
  always_comb begin
    load_val_s  = bus.val_in;
    time_next_s = time_r;
    if (bus.val_in > TIME_MAX) begin
      load_val_s = TIME_MAX;
    end else begin
      load_val_s = bus.val_in;
    end
    if (bus.load) begin
      time_next_s = load_val_s;
    end else if (sec_tick_s && (time_r != 14'd0)) begin
      time_next_s = time_r - 14'd1;
    end else begin
      time_next_s = time_r;
    end
  end

  // Next mode and blink phase; any mode change restarts with display on.
  always_comb begin
    mode_next_s  = classify(time_next_s);
    blank_next_s = 1'b0;
    if (mode_next_s != mode_r) begin
      blank_next_s = 1'b0;
    end else begin
      case (mode_r)
        MODE_NORMAL:  blank_next_s = 1'b0;
        MODE_LOW:     blank_next_s = blank_r ^ sec_tick_s;
        MODE_EXPIRED: blank_next_s = blank_r ^ half_tick_s;
        default:      blank_next_s = 1'b0;
      endcase
    end
  end

  // State register: time, mode and blink phase update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_r  <= 14'd0;
      mode_r  <= MODE_EXPIRED;
      blank_r <= 1'b0;
    end else begin
      time_r  <= time_next_s;
      mode_r  <= mode_next_s;
      blank_r <= blank_next_s;
    end
  end

  assign bus.time_out = time_r;
  assign bus.mode     = mode_r;
  assign bus.blank    = blank_r;

endmodule

// File: tb/tb_meter_timer.sv
// Scoreboard bench for meter_timer with CLK_HZ = 8 (second tick every 8
// cycles, half tick every 4). Edge numbers count rising edges since the
// last reset release; expectations are keyed to those edge numbers.
module tb_meter_timer;

  localparam logic [1:0] M_N = 2'd0;
  localparam logic [1:0] M_L = 2'd1;
  localparam logic [1:0] M_E = 2'd2;

  typedef struct {
    int          cyc;
    logic [13:0] t;
    logic [1:0]  m;
    logic        b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cnt;
  int   checks = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t e;

  meter_timer_if bus();

  meter_timer #(.CLK_HZ(8), .LOW_THRESH(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // edge counter since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;
  end

  // monitor: compare outputs against queued expectations on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc <= cnt) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cnt) begin
          bad++;
          $display("FAIL missed_edge_%0d: monitor now at edge %0d", e.cyc, cnt);
        end else if (bus.time_out !== e.t || bus.mode !== e.m || bus.blank !== e.b) begin
          bad++;
          $display("FAIL edge_%0d: got time=%0d mode=%0d blank=%0d, want time=%0d mode=%0d blank=%0d",
                   e.cyc, bus.time_out, bus.mode, bus.blank, e.t, e.m, e.b);
        end
      end
    end
  end

  task automatic push(input int c, input int t, input logic [1:0] m, input logic b);
    exp_t x;
    x.cyc = c;
    x.t   = 14'(t);
    x.m   = m;
    x.b   = b;
    sb.push_back(x);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (bus.time_out !== 14'd0 || bus.mode !== M_E || bus.blank !== 1'b0) begin
      bad++;
      $display("FAIL %s: got time=%0d mode=%0d blank=%0d, want time=0 mode=2 blank=0",
               tag, bus.time_out, bus.mode, bus.blank);
    end
  endtask

  task automatic wait_cnt(input int k);
    int guard;
    guard = 0;
    while (cnt != k) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL wait_edge_%0d: timed out at edge %0d", k, cnt);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic load_at(input int k, input int v);
    wait_cnt(k - 1);
    bus.val_in = 14'(v);
    bus.load   = 1'b1;
    @(posedge clk);
    #1;
    bus.load   = 1'b0;
  endtask

  initial begin
    bus.val_in = 14'd0;
    bus.load   = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset("reset_state");

    // countdown from 205 into LOW
    push(1, 0, M_E, 1'b0);
    push(2, 205, M_N, 1'b0);  push(7, 205, M_N, 1'b0);
    push(8, 204, M_N, 1'b0);  push(16, 203, M_N, 1'b0);
    push(24, 202, M_N, 1'b0); push(32, 201, M_N, 1'b0);
    push(40, 200, M_N, 1'b0); push(47, 200, M_N, 1'b0);
    push(48, 199, M_L, 1'b0);
    // slow blink in LOW, load inside LOW keeps phase
    push(50, 150, M_L, 1'b0); push(56, 149, M_L, 1'b1);
    push(63, 149, M_L, 1'b1); push(64, 148, M_L, 1'b0);
    push(72, 147, M_L, 1'b1); push(80, 146, M_L, 1'b0);
    // load coinciding with second tick
    push(84, 300, M_N, 1'b0); push(87, 300, M_N, 1'b0);
    push(88, 50, M_L, 1'b0);  push(95, 50, M_L, 1'b0);
    push(96, 49, M_L, 1'b1);
    // run down to zero, fast blink, no wrap
    push(98, 2, M_L, 1'b1);   push(103, 2, M_L, 1'b1);
    push(104, 1, M_L, 1'b0);  push(112, 0, M_E, 1'b0);
    push(116, 0, M_E, 1'b1);  push(120, 0, M_E, 1'b0);
    push(124, 0, M_E, 1'b1);  push(128, 0, M_E, 1'b0);
    // clamp and threshold boundaries
    push(130, 9999, M_N, 1'b0); push(132, 9999, M_N, 1'b0);
    push(134, 199, M_L, 1'b0);  push(136, 200, M_N, 1'b0);
    push(143, 200, M_N, 1'b0);  push(144, 199, M_L, 1'b0);
    push(146, 0, M_E, 1'b0);    push(148, 0, M_E, 1'b1);
    push(150, 0, M_E, 1'b1);
    // back into LOW, blanked phase before reset
    push(154, 150, M_L, 1'b0);  push(160, 149, M_L, 1'b1);
    push(161, 149, M_L, 1'b1);

    #10 rst_n = 1'b1;

    load_at(2, 205);
    load_at(50, 150);
    load_at(84, 300);
    load_at(88, 50);
    load_at(98, 2);
    load_at(130, 12000);
    load_at(132, 10000);
    load_at(134, 199);
    load_at(136, 200);
    load_at(146, 0);
    load_at(150, 0);
    load_at(154, 150);

    // asynchronous reset between edges while blanked in LOW
    wait_cnt(162);
    #1 rst_n = 1'b0;
    #1 check_reset("async_reset");
    push(1, 0, M_E, 1'b0);
    push(3, 0, M_E, 1'b0);
    push(4, 0, M_E, 1'b1);
    push(8, 0, M_E, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cnt(9);
    #6;

    checks++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
